// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner selection for the serial system bus, with
// grant/use/release tenure sequencing and one outstanding split transaction.
module bus_arbiter #(
  parameter int MASTER_NO     = 2,
  parameter int SLAVE_NO      = 3,
  parameter int GRANT_TIMEOUT = 8,
  parameter int OWNER_W       = $clog2(MASTER_NO)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MASTER_NO-1:0] m_bus_req,
  input  logic [MASTER_NO-1:0] m_bus_util,
  input  logic [SLAVE_NO-1:0]  s_split,
  input  logic [SLAVE_NO-1:0]  s_split_done,
  output logic [MASTER_NO-1:0] bus_grant,
  output logic [MASTER_NO-1:0] split_en,
  output logic [OWNER_W-1:0]   bus_owner,
  output logic                 bus_busy,
  output logic                 split_pending,
  output logic [1:0]           state_dbg
);

  localparam int SLV_W = (SLAVE_NO > 1) ? $clog2(SLAVE_NO) : 1;
  localparam int CNT_W = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
  localparam logic [MASTER_NO-1:0] ONE_HOT0 = MASTER_NO'(1);

  // Handshake: m_bus_req is a level held for the whole tenure. A registered
  // one-hot bus_grant answers it; the owner raises m_bus_util while using the
  // bus and the tenure ends when util falls, req falls in GRANT, the GRANT
  // wait times out, or a slave splits. Every tenure ends with one RELEASE cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [MASTER_NO-1:0] grant_q, grant_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [OWNER_W-1:0]   bus_owner_q, bus_owner_d;
  logic                 busy_q, busy_d;
  logic [OWNER_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MASTER_NO-1:0] split_en_q, split_en_d;
  logic                 pend_q, pend_d;
  logic                 resume_q, resume_d;
  logic [OWNER_W-1:0]   sm_q, sm_d;
  logic [SLV_W-1:0]     ss_q, ss_d;

  logic                 win_valid;
  logic [OWNER_W-1:0]   win_idx;
  logic [OWNER_W-1:0]   cand;
  logic [SLV_W-1:0]     split_k;

  // A resumable split master wins outright; otherwise search upward from
  // rr_ptr+1, skipping a split master whose slave has not signalled done.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (pend_q && resume_q && m_bus_req[sm_q]) begin
      win_valid = 1'b1;
      win_idx   = sm_q;
    end else begin
      for (int i = 1; i <= MASTER_NO; i++) begin
        cand = OWNER_W'((int'(rr_q) + i) % MASTER_NO);
        if (!win_valid && m_bus_req[cand] && !(pend_q && !resume_q && cand == sm_q)) begin
          win_valid = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    split_k = '0;
    for (int k = SLAVE_NO - 1; k >= 0; k--) begin
      if (s_split[k]) split_k = SLV_W'(k);
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    bus_owner_d = bus_owner_q;
    busy_d      = busy_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    split_en_d  = split_en_q;
    pend_d      = pend_q;
    resume_d    = resume_q | (pend_q & s_split_done[ss_q]);
    sm_d        = sm_q;
    ss_d        = ss_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d     = GRANT;
          grant_d     = ONE_HOT0 << win_idx;
          owner_d     = win_idx;
          bus_owner_d = win_idx;
          busy_d      = 1'b1;
          cnt_d       = '0;
          if (pend_q && win_idx == sm_q) begin
            split_en_d = '0;
            pend_d     = 1'b0;
            resume_d   = 1'b0;
          end
        end
      end
      GRANT: begin
        if (m_bus_util[owner_q]) begin
          state_d = BUSY;
        end else if (!m_bus_req[owner_q] || cnt_q == CNT_W'(GRANT_TIMEOUT - 1)) begin
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BUSY: begin
        if (|s_split && !pend_q) begin
          state_d    = RELEASE;
          pend_d     = 1'b1;
          resume_d   = 1'b0;
          sm_d       = owner_q;
          ss_d       = split_k;
          split_en_d = ONE_HOT0 << owner_q;
        end else if (!m_bus_util[owner_q]) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        rr_d    = owner_q;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == RELEASE) begin
      grant_d     = '0;
      bus_owner_d = '0;
      busy_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      bus_owner_q <= '0;
      busy_q      <= 1'b0;
      rr_q        <= OWNER_W'(MASTER_NO - 1);
      cnt_q       <= '0;
      split_en_q  <= '0;
      pend_q      <= 1'b0;
      resume_q    <= 1'b0;
      sm_q        <= '0;
      ss_q        <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      bus_owner_q <= bus_owner_d;
      busy_q      <= busy_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      split_en_q  <= split_en_d;
      pend_q      <= pend_d;
      resume_q    <= resume_d;
      sm_q        <= sm_d;
      ss_q        <= ss_d;
    end
  end

  assign bus_grant     = grant_q;
  assign split_en      = split_en_q;
  assign bus_owner     = bus_owner_q;
  assign bus_busy      = busy_q;
  assign split_pending = pend_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus randomized traffic checked against a
// tenure-level reference model of the arbiter.
module tb_bus_arbiter;
  localparam int N  = 2;
  localparam int S  = 3;
  localparam int T  = 8;
  localparam int OW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  m_bus_req = '0;
  logic [N-1:0]  m_bus_util = '0;
  logic [S-1:0]  s_split = '0;
  logic [S-1:0]  s_split_done = '0;
  logic [N-1:0]  bus_grant;
  logic [N-1:0]  split_en;
  logic [OW-1:0] bus_owner;
  logic          bus_busy;
  logic          split_pending;
  logic [1:0]    state_dbg;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: owner (-1 when nobody holds the bus), whether the tenure
  // has used the bus yet, cycles waited for first use, one-cycle release gap,
  // and the single outstanding split.
  int md_owner, md_last, md_rr, md_wait, md_sm, md_ss;
  bit md_used, md_gap, md_pend, md_rok;

  bus_arbiter #(.MASTER_NO(N), .SLAVE_NO(S), .GRANT_TIMEOUT(T)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m_bus_req    (m_bus_req),
    .m_bus_util   (m_bus_util),
    .s_split      (s_split),
    .s_split_done (s_split_done),
    .bus_grant    (bus_grant),
    .split_en     (split_en),
    .bus_owner    (bus_owner),
    .bus_busy     (bus_busy),
    .split_pending(split_pending),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    md_owner = -1; md_last = 0; md_rr = N - 1; md_wait = 0; md_sm = 0; md_ss = 0;
    md_used = 0; md_gap = 0; md_pend = 0; md_rok = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] req, util;
    logic [S-1:0] spl, dn;
    bit old_pend, fin;
    int o, k, win, c;
    req = m_bus_req; util = m_bus_util; spl = s_split; dn = s_split_done;
    old_pend = md_pend;
    fin = 0;
    if (md_owner >= 0) begin
      o = md_owner;
      if (!md_used) begin
        if (util[o]) md_used = 1;
        else if (!req[o]) fin = 1;
        else if (md_wait == T - 1) fin = 1;
        else md_wait++;
      end else begin
        if (spl != 0 && !md_pend) begin
          k = 0;
          for (int j = S - 1; j >= 0; j--) if (spl[j]) k = j;
          md_pend = 1; md_rok = 0; md_sm = o; md_ss = k; fin = 1;
        end else if (!util[o]) begin
          fin = 1;
        end
      end
      if (fin) begin md_last = o; md_owner = -1; md_gap = 1; end
    end else if (md_gap) begin
      md_gap = 0;
      md_rr = md_last;
    end else begin
      win = -1;
      if (md_pend && md_rok && req[md_sm]) win = md_sm;
      else begin
        for (int i = 1; i <= N; i++) begin
          c = (md_rr + i) % N;
          if (win < 0 && req[c] && !(md_pend && !md_rok && c == md_sm)) win = c;
        end
      end
      if (win >= 0) begin
        md_owner = win; md_used = 0; md_wait = 0;
        if (md_pend && win == md_sm) begin md_pend = 0; md_rok = 0; end
      end
    end
    if (old_pend && md_pend && dn[md_ss]) md_rok = 1;
  endtask

  function automatic logic [N-1:0] exp_grant();
    return (md_owner >= 0) ? (N'(1) << md_owner) : '0;
  endfunction
  function automatic logic [N-1:0] exp_split_en();
    return md_pend ? (N'(1) << md_sm) : '0;
  endfunction
  function automatic logic [OW-1:0] exp_owner();
    return (md_owner >= 0) ? OW'(md_owner) : '0;
  endfunction
  function automatic logic [1:0] exp_state();
    if (md_owner >= 0) return md_used ? 2'd2 : 2'd1;
    return md_gap ? 2'd3 : 2'd0;
  endfunction

  // One clock: model follows the same edge, outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_bus_req = '0; m_bus_util = '0; s_split = '0; s_split_done = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_bus_req = 2'b11;
    @(posedge clk); #1;
    total_cnt++;
    if ({bus_grant, split_en, bus_owner, bus_busy, split_pending} !== '0) $display("FAIL reset_outputs: got grant=%b split_en=%b owner=%0d busy=%b pend=%b, expected all 0", bus_grant, split_en, bus_owner, bus_busy, split_pending);
    else pass_cnt++;
    total_cnt++;
    if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state_dbg);
    else pass_cnt++;
    do_reset();
    m_bus_req = 2'b11;
    step();
    total_cnt++;
    if (bus_grant !== 2'b01) $display("FAIL reset_first_winner: got %b expected 01", bus_grant);
    else pass_cnt++;
    m_bus_req = '0;
    do_reset();
  endtask

  task automatic test_single();
    m_bus_req = 2'b01;
    step();
    total_cnt++;
    if (bus_grant !== 2'b01 || bus_busy !== 1'b1 || state_dbg !== 2'd1) $display("FAIL single_grant: got grant=%b busy=%b state=%0d expected 01/1/1", bus_grant, bus_busy, state_dbg);
    else pass_cnt++;
    step();
    m_bus_util = 2'b01;
    step();
    total_cnt++;
    if (state_dbg !== 2'd2) $display("FAIL single_busy: got state %0d expected 2", state_dbg);
    else pass_cnt++;
    repeat (9) step();
    total_cnt++;
    if (bus_grant !== 2'b01 || bus_owner !== 1'b0) $display("FAIL single_hold: got grant=%b owner=%0d expected 01/0", bus_grant, bus_owner);
    else pass_cnt++;
    m_bus_util = '0;
    m_bus_req = '0;
    step();
    total_cnt++;
    if (bus_grant !== 2'b00 || bus_busy !== 1'b0 || state_dbg !== 2'd3) $display("FAIL single_release: got grant=%b busy=%b state=%0d expected 00/0/3", bus_grant, bus_busy, state_dbg);
    else pass_cnt++;
    step();
    total_cnt++;
    if (state_dbg !== 2'd0 || bus_grant !== 2'b00) $display("FAIL single_idle: got state=%0d grant=%b expected 0/00", state_dbg, bus_grant);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_seq [3];
    int gap;
    bit seen;
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01;
    do_reset();
    m_bus_req = 2'b11;
    for (int t = 0; t < 3; t++) begin
      gap = 0;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
        step();
        if (bus_grant !== '0) seen = 1;
        else gap++;
      end
      total_cnt++;
      if (!seen) $display("FAIL contention_timeout: tenure %0d got no grant within 10 cycles, expected %b", t, exp_seq[t]);
      else pass_cnt++;
      total_cnt++;
      if (bus_grant !== exp_seq[t]) $display("FAIL contention_order: tenure %0d got %b expected %b", t, bus_grant, exp_seq[t]);
      else pass_cnt++;
      if (t > 0) begin
        total_cnt++;
        if (gap != 2) $display("FAIL contention_gap: tenure %0d got %0d idle cycles expected 2", t, gap);
        else pass_cnt++;
      end
      m_bus_util = exp_grant();
      repeat (2) step();
      m_bus_util = '0;
    end
    m_bus_req = '0;
    do_reset();
  endtask

  task automatic test_second_split();
    s_split = 3'b100;
    step();
    s_split = '0;
    total_cnt++;
    if (bus_grant !== 2'b10 || split_en !== 2'b01 || state_dbg !== 2'd2) $display("FAIL second_split: got grant=%b split_en=%b state=%0d expected 10/01/2", bus_grant, split_en, state_dbg);
    else pass_cnt++;
  endtask

  task automatic test_split();
    do_reset();
    m_bus_req = 2'b01;
    step();
    m_bus_util = 2'b01;
    step();
    m_bus_req = 2'b11;
    s_split = 3'b010;
    step();
    s_split = '0;
    m_bus_util = '0;
    total_cnt++;
    if (bus_grant !== 2'b00 || split_en !== 2'b01 || split_pending !== 1'b1) $display("FAIL split_suspend: got grant=%b split_en=%b pend=%b expected 00/01/1", bus_grant, split_en, split_pending);
    else pass_cnt++;
    repeat (2) step();
    total_cnt++;
    if (bus_grant !== 2'b10 || bus_owner !== 1'b1) $display("FAIL split_other_granted: got grant=%b owner=%0d expected 10/1", bus_grant, bus_owner);
    else pass_cnt++;
    m_bus_util = 2'b10;
    step();
    test_second_split();
    s_split_done = 3'b001;
    step();
    s_split_done = 3'b010;
    step();
    s_split_done = '0;
    step();
    m_bus_util = '0;
    repeat (2) step();
    total_cnt++;
    if (bus_grant !== 2'b00 || split_en !== 2'b01) $display("FAIL split_before_resume: got grant=%b split_en=%b expected 00/01", bus_grant, split_en);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus_grant !== 2'b01 || split_en !== 2'b00 || split_pending !== 1'b0) $display("FAIL split_resume: got grant=%b split_en=%b pend=%b expected 01/00/0", bus_grant, split_en, split_pending);
    else pass_cnt++;
    m_bus_req = '0;
    do_reset();
  endtask

  task automatic test_timeout();
    int high;
    do_reset();
    m_bus_req = 2'b10;
    step();
    high = (bus_grant === 2'b10) ? 1 : 0;
    for (int c = 0; c < 20 && bus_grant !== 2'b00; c++) begin
      step();
      if (bus_grant === 2'b10) high++;
    end
    total_cnt++;
    if (high != T) $display("FAIL timeout_length: got %0d grant cycles expected %0d", high, T);
    else pass_cnt++;
    total_cnt++;
    if (state_dbg !== 2'd3) $display("FAIL timeout_release: got state %0d expected 3", state_dbg);
    else pass_cnt++;
    step();
    total_cnt++;
    if (state_dbg !== 2'd0 || bus_grant !== 2'b00) $display("FAIL timeout_idle: got state=%0d grant=%b expected 0/00", state_dbg, bus_grant);
    else pass_cnt++;
    m_bus_req = '0;
    do_reset();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_bus_req = 2'b10;
    step();
    m_bus_util = 2'b10;
    step();
    m_bus_req = 2'b11;
    s_split = 3'b001;
    step();
    s_split = '0;
    m_bus_util = '0;
    repeat (2) step();
    m_bus_util = 2'b01;
    step();
    total_cnt++;
    if (bus_grant !== 2'b01 || split_pending !== 1'b1 || state_dbg !== 2'd2) $display("FAIL reset_mid_setup: got grant=%b pend=%b state=%0d expected 01/1/2", bus_grant, split_pending, state_dbg);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus_grant, split_en, bus_owner, bus_busy, split_pending} !== '0 || state_dbg !== 2'd0) $display("FAIL reset_mid_clear: got grant=%b split_en=%b owner=%0d busy=%b pend=%b state=%0d expected all 0", bus_grant, split_en, bus_owner, bus_busy, split_pending, state_dbg);
    else pass_cnt++;
    do_reset();
    m_bus_req = 2'b11;
    step();
    total_cnt++;
    if (bus_grant !== 2'b01) $display("FAIL reset_mid_regrant: got %b expected 01", bus_grant);
    else pass_cnt++;
    m_bus_req = '0;
    do_reset();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) m_bus_req = N'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) m_bus_util = N'($urandom_range(0, 3));
      s_split = ($urandom_range(0, 5) == 0) ? S'($urandom_range(1, 7)) : '0;
      s_split_done = ($urandom_range(0, 5) == 0) ? S'($urandom_range(1, 7)) : '0;
      step();
      total_cnt++;
      if (bus_grant !== exp_grant() || split_en !== exp_split_en() || bus_owner !== exp_owner() ||
          bus_busy !== (md_owner >= 0) || split_pending !== md_pend || state_dbg !== exp_state()) begin
        if (errs < 10) $display("FAIL random_cycle %0d: got grant=%b split_en=%b owner=%0d busy=%b pend=%b state=%0d expected %b/%b/%0d/%b/%b/%0d",
                                c, bus_grant, split_en, bus_owner, bus_busy, split_pending, state_dbg,
                                exp_grant(), exp_split_en(), exp_owner(), md_owner >= 0, md_pend, exp_state());
        errs++;
      end else pass_cnt++;
      total_cnt++;
      if (!$onehot0(bus_grant)) $display("FAIL random_onehot %0d: got grant=%b expected at most one bit", c, bus_grant);
      else pass_cnt++;
    end
    do_reset();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_split();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
